// File: rtl/hexa_link_pkg.sv
// Shared definitions for the link drain: state encoding, tail position and clog2.
package hexa_link_pkg;

    localparam int LINK_DWIDTH = 32;
    localparam int TAIL_BIT    = LINK_DWIDTH - 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } link_state_e;

    // Number of bits needed to count 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Tail marker sits in the MSB of a flit of the given width.
    function automatic int tail_pos(input int dwidth);
        return dwidth - 1;
    endfunction

endpackage

// File: rtl/up_down_counter.sv
// Saturating up/down counter used for the FIFO occupancy mirror and the credit pool.
module up_down_counter #(
    parameter int WIDTH     = 5,
    parameter int MAX       = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             inc_qualify_not_full,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             inc_eff;

    assign at_max   = (count_q == MAX_V);
    assign at_zero  = (count_q == '0);
    assign inc_eff  = inc && !(inc_qualify_not_full && at_max);
    assign overflow = inc_eff && !dec && at_max;
    assign count    = count_q;

    // Net change: +1, -1 or hold; a simultaneous inc/dec cancels, and the ends saturate.
    always_comb begin
        count_d = count_q;
        if (inc_eff && !dec && !at_max) begin
            count_d = count_q + ONE_V;
        end else if (dec && !inc_eff && !at_zero) begin
            count_d = count_q - ONE_V;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RESET_V;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_link_drain.sv
// Drains the local FIFO onto a credit-flow-controlled link and tracks packet framing.
module fifo_link_drain
    import hexa_link_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int FDEPTH  = 16,
    parameter int CREDITS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_wr_strobe,
    input  logic [DWIDTH-1:0] fifo_rd_data,
    output logic              fifo_rd_strobe,
    input  logic              credit_in,
    output logic              link_valid,
    output logic [DWIDTH-1:0] link_data,
    output logic              pkt_busy,
    output logic              credit_err
);

    localparam int OCC_W  = clog2(FDEPTH + 1);
    localparam int CRED_W = clog2(CREDITS + 1);
    localparam int TAIL   = tail_pos(DWIDTH);

    logic [OCC_W-1:0]  occ;
    logic [CRED_W-1:0] cred;
    logic              occ_at_max, occ_at_zero, occ_overflow;
    logic              cred_at_max, cred_at_zero, cred_overflow;
    logic              send;
    logic              unused_sigs;

    logic              link_valid_q, link_valid_d;
    logic [DWIDTH-1:0] link_data_q, link_data_d;
    logic              pkt_busy_q;
    logic              credit_err_q, credit_err_d;
    link_state_e       state_q, state_d;

    // Occupancy mirror: writes at full are dropped exactly as the FIFO drops them.
    up_down_counter #(
        .WIDTH     (OCC_W),
        .MAX       (FDEPTH),
        .RESET_VAL (0)
    ) u_occ (
        .clk                  (clk),
        .rst_n                (rst),
        .inc                  (fifo_wr_strobe),
        .dec                  (send),
        .inc_qualify_not_full (1'b1),
        .count                (occ),
        .at_max               (occ_at_max),
        .at_zero              (occ_at_zero),
        .overflow             (occ_overflow)
    );

    // Credit pool: a credit at the ceiling saturates and raises overflow.
    up_down_counter #(
        .WIDTH     (CRED_W),
        .MAX       (CREDITS),
        .RESET_VAL (CREDITS)
    ) u_cred (
        .clk                  (clk),
        .rst_n                (rst),
        .inc                  (credit_in),
        .dec                  (send),
        .inc_qualify_not_full (1'b0),
        .count                (cred),
        .at_max               (cred_at_max),
        .at_zero              (cred_at_zero),
        .overflow             (cred_overflow)
    );

    assign send           = !occ_at_zero && !cred_at_zero;
    assign fifo_rd_strobe = send;
    assign unused_sigs    = ^{occ, cred, occ_at_max, occ_overflow, cred_at_max};

    assign link_valid = link_valid_q;
    assign link_data  = link_data_q;
    assign pkt_busy   = pkt_busy_q;
    assign credit_err = credit_err_q;

    // Next-state for the output stage, the framing FSM and the sticky credit error.
    always_comb begin
        link_valid_d = send;
        link_data_d  = link_data_q;
        state_d      = state_q;
        credit_err_d = credit_err_q | cred_overflow;
        if (send) begin
            link_data_d = fifo_rd_data;
            state_d     = fifo_rd_data[TAIL] ? ST_IDLE : ST_PKT;
        end
    end

    // Output registers and framing FSM; pkt_busy is registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            link_valid_q <= 1'b0;
            link_data_q  <= '0;
            state_q      <= ST_IDLE;
            pkt_busy_q   <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            link_valid_q <= link_valid_d;
            link_data_q  <= link_data_d;
            state_q      <= state_d;
            pkt_busy_q   <= (state_d == ST_PKT);
            credit_err_q <= credit_err_d;
        end
    end

endmodule

// File: tb/tb_fifo_link_drain.sv
// Bench for fifo_link_drain: behavioural FIFO, reference model and data scoreboard.
module tb_fifo_link_drain;

    localparam int DW = 32;
    localparam int FD = 16;
    localparam int CR = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fifo_wr_strobe = 1'b0;
    logic          credit_in = 1'b0;
    logic [DW-1:0] wrData = '0;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_strobe;
    logic          link_valid;
    logic [DW-1:0] link_data;
    logic          pkt_busy;
    logic          credit_err;

    int errors = 0;
    int checks = 0;
    int sendCount = 0;
    int baseCount = 0;
    logic monOn = 1'b0;

    logic [DW-1:0] expQ[$];

    logic [DW-1:0] fifoMem[FD];
    int fifoRd = 0;
    int fifoWr = 0;
    int fifoCount = 0;

    int   occM = 0;
    int   credM = CR;
    logic errM = 1'b0;
    logic validM = 1'b0;
    logic busyM = 1'b0;
    logic sendNowM;

    typedef struct {
        logic          wr;
        logic [DW-1:0] data;
        logic          cr;
        logic          expStrobe;
        logic          expValid;
        logic [DW-1:0] expData;
        logic          expBusy;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    fifo_link_drain #(
        .DWIDTH  (DW),
        .FDEPTH  (FD),
        .CREDITS (CR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_wr_strobe (fifo_wr_strobe),
        .fifo_rd_data   (fifo_rd_data),
        .fifo_rd_strobe (fifo_rd_strobe),
        .credit_in      (credit_in),
        .link_valid     (link_valid),
        .link_data      (link_data),
        .pkt_busy       (pkt_busy),
        .credit_err     (credit_err)
    );

    // Behavioural FIFO feeding the DUT through an asynchronous read port.
    assign fifo_rd_data = fifoMem[fifoRd];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifoRd    <= 0;
            fifoWr    <= 0;
            fifoCount <= 0;
        end else begin
            if (fifo_wr_strobe && fifoCount < FD) begin
                fifoMem[fifoWr] <= wrData;
                fifoWr <= (fifoWr + 1) % FD;
            end
            if (fifo_rd_strobe && fifoCount > 0) begin
                fifoRd <= (fifoRd + 1) % FD;
            end
            fifoCount <= fifoCount + ((fifo_wr_strobe && fifoCount < FD) ? 1 : 0)
                                   - ((fifo_rd_strobe && fifoCount > 0) ? 1 : 0);
        end
    end

    // Reference model of occupancy, credits, framing and the sticky error.
    assign sendNowM = (occM != 0) && (credM != 0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            occM   <= 0;
            credM  <= CR;
            errM   <= 1'b0;
            validM <= 1'b0;
            busyM  <= 1'b0;
        end else begin
            occM <= occM + ((fifo_wr_strobe && occM != FD) ? 1 : 0) - (sendNowM ? 1 : 0);
            if (credit_in && !sendNowM && credM == CR) begin
                errM <= 1'b1;
            end else begin
                credM <= credM + (credit_in ? 1 : 0) - (sendNowM ? 1 : 0);
            end
            validM <= sendNowM;
            if (sendNowM) begin
                busyM <= ~fifo_rd_data[DW-1];
            end
        end
    end

    function automatic void checkOutput(input string name, input logic [DW-1:0] act,
                                        input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    // Per-cycle monitor: model comparison plus in-order data scoreboard.
    always @(negedge clk) begin
        if (rst && monOn) begin
            checkOutput("mon_rd_strobe", {31'd0, fifo_rd_strobe}, {31'd0, sendNowM});
            checkOutput("mon_link_valid", {31'd0, link_valid}, {31'd0, validM});
            checkOutput("mon_pkt_busy", {31'd0, pkt_busy}, {31'd0, busyM});
            checkOutput("mon_credit_err", {31'd0, credit_err}, {31'd0, errM});
            if (link_valid) begin
                sendCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard: got flit %0h, required no flit", link_data);
                end else begin
                    checkOutput("mon_link_data", link_data, expQ.pop_front());
                end
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [DW-1:0] d, input logic cr);
        fifo_wr_strobe = wr;
        wrData         = d;
        credit_in      = cr;
        if (wr && fifoCount < FD) expQ.push_back(d);
        @(posedge clk);
        #1;
        fifo_wr_strobe = 1'b0;
        credit_in      = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_000A, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_000B, 1'b0, 1'b1, 1'b1, 32'h0000_000A, 1'b1};
        vecs[2] = '{1'b1, 32'h8000_000C, 1'b0, 1'b1, 1'b1, 32'h0000_000B, 1'b1};
        vecs[3] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_000C, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_000C, 1'b0};

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_link_valid", {31'd0, link_valid}, 32'd0);
        checkOutput("rst_link_data", link_data, 32'd0);
        checkOutput("rst_pkt_busy", {31'd0, pkt_busy}, 32'd0);
        checkOutput("rst_credit_err", {31'd0, credit_err}, 32'd0);
        checkOutput("rst_rd_strobe", {31'd0, fifo_rd_strobe}, 32'd0);
        rst   = 1'b1;
        monOn = 1'b1;

        // Basic send through the vector table.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].data, vecs[i].cr);
            checkOutput($sformatf("vec%0d_rd_strobe", i), {31'd0, fifo_rd_strobe}, {31'd0, vecs[i].expStrobe});
            checkOutput($sformatf("vec%0d_link_valid", i), {31'd0, link_valid}, {31'd0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d_link_data", i), link_data, vecs[i].expData);
            checkOutput($sformatf("vec%0d_pkt_busy", i), {31'd0, pkt_busy}, {31'd0, vecs[i].expBusy});
        end

        // Credit exhaustion: 13 credits left, 15 flits offered.
        baseCount = sendCount;
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 32'h100 + i, 1'b0);
        repeat (3) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("exhaust_sent", sendCount - baseCount, 32'd13);
        checkOutput("exhaust_cred", {27'd0, dut.cred}, 32'd0);
        checkOutput("exhaust_occ", {27'd0, dut.occ}, 32'd2);
        checkOutput("exhaust_rd_strobe", {31'd0, fifo_rd_strobe}, 32'd0);

        // Full mirror: 18 writes with no credits saturate occupancy.
        for (int i = 0; i < 18; i++) applyStimulus(1'b1, 32'h200 + i, 1'b0);
        checkOutput("full_occ", {27'd0, dut.occ}, 32'd16);
        checkOutput("full_link_valid", {31'd0, link_valid}, 32'd0);

        // One credit: pop next cycle, then write-at-full + send + credit together.
        baseCount = sendCount;
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("credit_rd_strobe", {31'd0, fifo_rd_strobe}, 32'd1);
        checkOutput("credit_link_valid", {31'd0, link_valid}, 32'd0);
        checkOutput("credit_cred", {27'd0, dut.cred}, 32'd1);
        applyStimulus(1'b1, 32'h2FF, 1'b1);
        checkOutput("simul_occ", {27'd0, dut.occ}, 32'd15);
        checkOutput("simul_cred", {27'd0, dut.cred}, 32'd1);
        checkOutput("simul_link_valid", {31'd0, link_valid}, 32'd1);

        // Restore credits one per cycle: the whole saturated FIFO drains.
        repeat (15) applyStimulus(1'b0, '0, 1'b1);
        repeat (2) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("restore_sent", sendCount - baseCount, 32'd16);
        checkOutput("restore_occ", {27'd0, dut.occ}, 32'd0);
        checkOutput("restore_cred", {27'd0, dut.cred}, 32'd1);

        // Write and send in the same cycle at occupancy 3.
        applyStimulus(1'b1, 32'h300, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        for (int i = 1; i < 4; i++) applyStimulus(1'b1, 32'h300 + i, 1'b0);
        checkOutput("occ3_setup", {27'd0, dut.occ}, 32'd3);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b1, 32'h8000_0304, 1'b0);
        checkOutput("occ3_hold", {27'd0, dut.occ}, 32'd3);
        checkOutput("occ3_cred", {27'd0, dut.cred}, 32'd0);

        // Refill the credit pool to its ceiling.
        for (int i = 0; i < 40 && credM != CR; i++) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("refill_cred", {27'd0, dut.cred}, 32'd16);
        checkOutput("refill_drained", expQ.size(), 32'd0);
        checkOutput("refill_pkt_busy", {31'd0, pkt_busy}, 32'd0);
        checkOutput("refill_credit_err", {31'd0, credit_err}, 32'd0);

        // Credit overflow is sticky.
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("ovf_credit_err", {31'd0, credit_err}, 32'd1);
        checkOutput("ovf_cred", {27'd0, dut.cred}, 32'd16);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b0);
            checkOutput($sformatf("ovf_sticky%0d", i), {31'd0, credit_err}, 32'd1);
        end

        // Reset in the middle of a packet.
        applyStimulus(1'b1, 32'h1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("mid_pkt_busy", {31'd0, pkt_busy}, 32'd1);
        checkOutput("mid_link_data", link_data, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_pkt_busy", {31'd0, pkt_busy}, 32'd0);
        checkOutput("arst_link_valid", {31'd0, link_valid}, 32'd0);
        checkOutput("arst_link_data", link_data, 32'd0);
        checkOutput("arst_credit_err", {31'd0, credit_err}, 32'd0);
        expQ.delete();
        @(negedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("post_rst_cred", {27'd0, dut.cred}, 32'd16);
        checkOutput("post_rst_occ", {27'd0, dut.occ}, 32'd0);
        checkOutput("post_rst_link_valid", {31'd0, link_valid}, 32'd0);

        monOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_link_drain.md
# fifo_link_drain

Output-side drain stage that sits directly downstream of the local `fifo`. It mirrors the FIFO's occupancy from the write strobe, pops flits through the FIFO's asynchronous read port, and forwards them onto a credit-flow-controlled link. It tracks downstream buffer credits and packet framing so that an upstream arbiter can see when a multi-flit packet owns the link.

## Interface
Parameters:
- `DWIDTH`, 32: flit width. Bit `DWIDTH-1` is the tail marker.
- `FDEPTH`, 16: depth of the local FIFO being drained. Must equal that FIFO's `FDEPTH`.
- `CREDITS`, 16: downstream receive buffer depth, which is also the credit count after reset.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `fifo_wr_strobe`  in  1: the same `wr_strobe` that drives the local FIFO.
- `fifo_rd_data`  in  DWIDTH: the FIFO's combinational `rd_data`.
- `fifo_rd_strobe`  out  1: pop request to the FIFO.
- `credit_in`  in  1: one downstream slot freed this cycle.
- `link_valid`  out  1: registered; flit on `link_data` is valid.
- `link_data`  out  DWIDTH: registered outgoing flit.
- `pkt_busy`  out  1: a packet has started on the link but its tail has not yet been sent.
- `credit_err`  out  1: sticky flag; a credit arrived while the credit counter was already at `CREDITS`.

## Operation
- **Occupancy counter `occ`**
  - Width `clog2(FDEPTH+1)`; range 0..FDEPTH.
  - Increments on `fifo_wr_strobe` only when `occ != FDEPTH`, matching the FIFO's `push = wr & ~full`.
  - Decrements on `fifo_rd_strobe`.
  - Write ignored at full and read in the same cycle: net -1.
  - Accepted write and read in the same cycle: unchanged.
- **Credit counter `cred`**
  - Width `clog2(CREDITS+1)`; range 0..CREDITS.
  - Decrements on send; increments on `credit_in`.
  - Send and `credit_in` in the same cycle: unchanged.
  - `credit_in` at `cred == CREDITS` without a send: counter saturates and `credit_err` is set until reset.
- **Send condition**
  - `send = (occ != 0) && (cred != 0)`, purely combinational.
  - `fifo_rd_strobe = send`.
  - On `send`: `link_data <= fifo_rd_data` and `link_valid <= 1`.
  - Otherwise `link_valid <= 0` and `link_data` holds its last value.
- **Framing FSM**, two states:
  - IDLE: a sent flit with tail = 0 moves to PKT. A tail = 1 flit is a single-flit packet and stays in IDLE.
  - PKT: a sent flit with tail = 1 returns to IDLE. Otherwise stay in PKT.
  - `pkt_busy` is a registered output, 1 exactly when the state is PKT.
- **No reads beyond occupancy**: the block never pops an empty FIFO and never sends without a credit.

## Timing
- **Reset values**: `occ` = 0, `cred` = CREDITS, state = IDLE, `link_valid` = 0, `link_data` = 0, `pkt_busy` = 0, `credit_err` = 0. `fifo_rd_strobe` is 0 because `occ` = 0.
- **Write-to-link latency**: a flit written at cycle t is counted at t+1, popped at t+1 if a credit is available, and appears on `link_valid`/`link_data` at t+2.
- **Credit-to-send latency**: a credit arriving at cycle t can enable a send at t+1.
- **Throughput**: one flit per cycle while `occ > 0` and `cred > 0`.
- **Wrap-around**:
  - `occ` goes 1 → 0 and FDEPTH-1 → FDEPTH without glitches.
  - `cred` goes 1 → 0, which stalls sending; the next credit resumes it.
- **Reset asserted mid-packet**: all state returns to reset values immediately, and `pkt_busy` drops asynchronously. FIFO contents are not this block's concern; the FIFO shares the same reset domain.

## Structure
- **Shared package `hexa_link_pkg`**:
  - `TAIL_BIT` position, defined as `DWIDTH-1`.
  - FSM state encoding: IDLE = 0, PKT = 1.
  - The `clog2` function.
- **Sub-module `up_down_counter`**:
  - Parameters: `WIDTH`, `MAX`, `RESET_VAL`.
  - Inputs: `inc`, `dec`, `inc_qualify_not_full`.
  - Outputs: `count`, `at_max`, `at_zero`, `overflow`.
  - Instantiated twice: once for `occ`, once for `cred`.
- **Top level**: the send logic, output registers and the FSM live in `fifo_link_drain` itself.

## Test plan
- **Basic send**: after reset, write 3 flits 0xA, 0xB, 0x8000_000C with `CREDITS` = 16. Required: `link_valid` high for 3 consecutive cycles starting 2 cycles after the first write, data in order, `pkt_busy` high after 0xA and low after 0x8000_000C.
- **Credit exhaustion**: `CREDITS` = 2, write 4 flits, no `credit_in`. Required: exactly 2 flits sent and `fifo_rd_strobe` stays low. Then pulse `credit_in` once: exactly 1 more flit follows, 1 cycle later.
- **Full mirror**: hold credits at 0 and strobe 18 writes with `FDEPTH` = 16. Required: `occ` saturates at 16. After credits are restored, exactly 16 flits are sent.
- **Simultaneous events**:
  - At `occ` = 16, `cred` = 5: `fifo_wr_strobe`, send and `credit_in` together. Required: `occ` = 15, `cred` = 5.
  - At `occ` = 3: write and send together. Required: `occ` = 3.
- **Credit overflow**: `credit_in` pulsed while `cred` = CREDITS with no traffic. Required: `credit_err` = 1 and stays 1 until `rst` is asserted.
- **Reset mid-packet**: send head flit 0x1, then assert `rst` low. Required: `pkt_busy`, `link_valid` and `link_data` are 0 immediately, and `cred` = CREDITS after release.
